runway_light_seq: RTL and testbench
===================================

// Module: runway_light_seq
// PURPOSE
//  Parametrised runway hazard-light sequencer: drives N_LIGHTS lamps in one of four modes (calm, sweep
//  right-to-left, sweep left-to-right, mode 3) selected by a 2-bit mode input. Next generation of the
//  3-lamp airport light FSM: generalised width, built-in step prescaler (no external divided clock),
//  mode changes aligned to steps, defined freeze/flash mode. Sits between board switches and LEDR.
// PARAMETERS
//  N_LIGHTS  8   number of lamps, >=3; bit N_LIGHTS-1 = leftmost lamp
//  TICK_DIV  4   Clock cycles per pattern step, >=1 (board build: 8_388_608 ~ 6 Hz at 50 MHz)
// PORTS
//  Clock   in   1         system clock; single clock domain
//  Reset   in   1         synchronous, active-high reset
//  mode    in   2         00 calm, 01 sweep R->L, 10 sweep L->R, 11 hold/flash; synchronous to Clock
//  lights  out  N_LIGHTS  lamp drive, registered, 1 = lit
//  tick    out  1         step strobe, high one cycle per TICK_DIV cycles
// BEHAVIOUR
//  - Reset (wins over everything, incl. coincident tick): cnt=0, mode_r=calm, phase=A,
//    lights = ends pattern (bit N-1 and bit 0 set only), tick=0 next cycle.
//  - Prescaler: cnt counts 0..TICK_DIV-1, wraps to 0; tick = (cnt==TICK_DIV-1), combinational from cnt.
//    TICK_DIV=1 -> tick permanently high after reset. First tick = TICK_DIV cycles after Reset drops.
//  - lights / mode_r / phase update only on the edge ending a tick cycle; otherwise hold.
//    mode is sampled only in tick cycles; changes between ticks are ignored until the next tick.
//  - At a tick, if mode != mode_r: load seed of new mode, mode_r <= mode. Else advance current mode.
//  - Seeds: calm -> ends pattern, phase A; 01 -> 1 at bit 0; 10 -> 1 at bit N-1;
//    11 -> see CONFIGURATION.
//  - Calm advance: toggle phase; A = ends pattern, B = bitwise complement of A (all inner lamps).
//  - 01 advance: rotate left (bit0->bit1 ... bit N-1 wraps to bit0). 10 advance: rotate right
//    (bit N-1 -> ... -> bit0, bit0 wraps to bit N-1). Exactly one lamp lit in either sweep.
//  - N_LIGHTS=3, any mode: sequence equals legacy lamps (101/010, 001-010-100, 100-010-001).
//  - No state goes unreachable: lights only ever loaded from seed or advance logic; no X outputs.
// CONFIGURATION
//  RUNWAY_FLASH_EN defined: mode 11 = flash; seed all-ones, each further tick bitwise invert
//    (all on / all off).
//  RUNWAY_FLASH_EN undefined: mode 11 = hold; at entry tick and every tick while in 11, lights hold
//    last value. Leaving 11 loads the seed of the new mode at the next tick.
// STRUCTURE
//  - Package runway_pkg: typedef enum logic [1:0] mode_t {MODE_CALM=2'b00, MODE_R2L=2'b01,
//    MODE_L2R=2'b10, MODE_AUX=2'b11}; function ends_pattern(N).
//  - Sub-module runway_tick_gen #(TICK_DIV) (Clock, Reset, tick): prescaler counter, width
//    $clog2(TICK_DIV)+1.
//  - Top: mode_r register, phase bit, lights register, seed/advance mux.
// TESTING (N_LIGHTS=8, TICK_DIV=4)
//  1. Reset 2 cycles, mode=00 -> lights=8'h81. Ticks at cycles 4, 8, 12 after release ->
//     lights 8'h7E, 8'h81, 8'h7E.
//  2. mode=10 from calm -> next tick 8'h80, then 40,20,...,01, then wraps to 8'h80.
//  3. mode=01 -> 8'h01, 02, ..., 80, wraps to 8'h01; switch to 10 mid-sweep at 8'h08 ->
//     next tick 8'h80 (seed, not continue).
//  4. Mode change 1 cycle after a tick, reverted 1 cycle later -> no visible change;
//    change held across a tick applies exactly at that tick.
//  5. mode=11 while lights=8'h20 -> without macro 8'h20 held for 10 ticks;
//     with RUNWAY_FLASH_EN FF,00,FF,00. Back to 00 -> 8'h81.
//  6. Reset asserted in a tick cycle during sweep -> lights=8'h81 (not advanced), tick low,
//     next tick exactly 4 cycles after release.

Source files
------------

// File: rtl/runway_pkg.sv
// Shared types and helpers for the runway hazard-light sequencer.
package runway_pkg;

  // Lamp modes as presented on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_CALM = 2'b00,
    MODE_R2L  = 2'b01,
    MODE_L2R  = 2'b10,
    MODE_AUX  = 2'b11
  } mode_t;

  // Calm-mode phase: A shows the two end lamps, B shows the inner lamps.
  typedef enum logic {
    PHASE_A = 1'b0,
    PHASE_B = 1'b1
  } phase_t;

  // Widest lamp bank the pattern helper can describe.
  localparam int MAX_LIGHTS = 64;

  // Pattern with only the leftmost (bit n-1) and rightmost (bit 0) lamps lit.
  function automatic logic [MAX_LIGHTS-1:0] ends_pattern(input int n);
    logic [MAX_LIGHTS-1:0] r_pat;
    r_pat        = '0;
    r_pat[0]     = 1'b1;
    r_pat[n-1]   = 1'b1;
    return r_pat;
  endfunction

endpackage

// File: rtl/runway_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and strobes tick on the last count.
// With TICK_DIV=1 the counter never leaves zero, so tick stays high.
module runway_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int                 CNT_W = $clog2(TICK_DIV) + 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running modulo-TICK_DIV counter, cleared by reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/runway_light_seq.sv
// Runway hazard-light sequencer top.
// Drives N_LIGHTS lamps in calm / sweep R->L / sweep L->R / mode-3 patterns.
// Lamp state only moves on a prescaler tick; a mode change loads the new
// mode's seed at the tick that sees it, otherwise the current mode advances.
// Build option: define RUNWAY_FLASH_EN to make mode 3 flash all lamps;
// without it mode 3 freezes the lamps at their last value.
module runway_light_seq
  import runway_pkg::*;
#(
  parameter int N_LIGHTS = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          mode,
  output logic [N_LIGHTS-1:0] lights,
  output logic                tick
);

  localparam logic [MAX_LIGHTS-1:0] ENDS_FULL = ends_pattern(N_LIGHTS);
  localparam logic [N_LIGHTS-1:0]   ENDS      = ENDS_FULL[N_LIGHTS-1:0];
  localparam logic [N_LIGHTS-1:0]   SEED_R2L  = {{(N_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [N_LIGHTS-1:0]   SEED_L2R  = {1'b1, {(N_LIGHTS-1){1'b0}}};

  logic                w_tick;
  mode_t               w_mode;
  mode_t               r_mode;
  phase_t              r_phase;
  logic [N_LIGHTS-1:0] r_lights;
  logic [N_LIGHTS-1:0] w_next_lights;
  phase_t              w_next_phase;

  runway_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (w_tick)
  );

  assign w_mode = mode_t'(mode);

  // Seed/advance mux: what the lamps and phase become at the next tick.
  always_comb begin
    w_next_lights = r_lights;
    w_next_phase  = r_phase;
    if (w_mode != r_mode) begin
      w_next_phase = PHASE_A;
      case (w_mode)
        MODE_CALM: w_next_lights = ENDS;
        MODE_R2L:  w_next_lights = SEED_R2L;
        MODE_L2R:  w_next_lights = SEED_L2R;
`ifdef RUNWAY_FLASH_EN
        MODE_AUX:  w_next_lights = '1;
`else
        MODE_AUX:  w_next_lights = r_lights;
`endif
        default:   w_next_lights = ENDS;
      endcase
    end else begin
      case (r_mode)
        MODE_CALM: begin
          if (r_phase == PHASE_A) begin
            w_next_lights = ~ENDS;
            w_next_phase  = PHASE_B;
          end else begin
            w_next_lights = ENDS;
            w_next_phase  = PHASE_A;
          end
        end
        MODE_R2L:  w_next_lights = {r_lights[N_LIGHTS-2:0], r_lights[N_LIGHTS-1]};
        MODE_L2R:  w_next_lights = {r_lights[0], r_lights[N_LIGHTS-1:1]};
`ifdef RUNWAY_FLASH_EN
        MODE_AUX:  w_next_lights = ~r_lights;
`else
        MODE_AUX:  w_next_lights = r_lights;
`endif
        default:   w_next_lights = ENDS;
      endcase
    end
  end

  // Lamp state registers: reset wins, otherwise update only on tick cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_mode   <= MODE_CALM;
      r_phase  <= PHASE_A;
      r_lights <= ENDS;
    end else if (w_tick) begin
      r_mode   <= w_mode;
      r_phase  <= w_next_phase;
      r_lights <= w_next_lights;
    end
  end

  assign lights = r_lights;
  assign tick   = w_tick;

endmodule

// File: tb/tb_runway_light_seq.sv
// Directed testbench for runway_light_seq (N_LIGHTS=8, TICK_DIV=4).
// Honours RUNWAY_FLASH_EN for the mode-3 expectations.
module tb_runway_light_seq;

  logic       Clock;
  logic       Reset;
  logic [1:0] mode;
  logic [7:0] lights;
  logic       tick;

  int checks = 0;
  int errors = 0;

  runway_light_seq #(
    .N_LIGHTS (8),
    .TICK_DIV (4)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .mode   (mode),
    .lights (lights),
    .tick   (tick)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Run until the cycle after the next tick strobe (i.e. just after the update edge).
  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: tick not seen within 8 cycles (got 0, want 1)", name);
    end
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    mode  = 2'b00;
    step();
    step();
    checks++;
    if (lights !== 8'h81) begin
      errors++;
      $display("FAIL reset_lights: got %h want 81", lights);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: got %b want 0", tick);
    end
    $display("[%0t] reset lights=%h tick=%b", $time, lights, tick);
    Reset = 1'b0;
  endtask

  task automatic test_calm();
    logic [7:0] exp_seq [3];
    logic [7:0] prev;
    exp_seq = '{8'h7E, 8'h81, 8'h7E};
    prev = 8'h81;
    for (int t = 0; t < 3; t++) begin
      for (int c = 1; c <= 3; c++) begin
        step();
        checks++;
        if (tick !== (c == 3)) begin
          errors++;
          $display("FAIL calm_tick t%0d c%0d: got %b want %b", t, c, tick, (c == 3));
        end
        checks++;
        if (lights !== prev) begin
          errors++;
          $display("FAIL calm_hold t%0d c%0d: got %h want %h", t, c, lights, prev);
        end
      end
      step();
      checks++;
      if (lights !== exp_seq[t]) begin
        errors++;
        $display("FAIL calm_step%0d: got %h want %h", t, lights, exp_seq[t]);
      end
      $display("[%0t] calm step %0d lights=%h", $time, t, lights);
      prev = exp_seq[t];
    end
  endtask

  task automatic test_sweep_l2r();
    logic [7:0] exp_v;
    mode = 2'b10;
    for (int i = 0; i < 9; i++) begin
      wait_tick("l2r");
      exp_v = 8'h80 >> (i % 8);
      checks++;
      if (lights !== exp_v) begin
        errors++;
        $display("FAIL l2r_step%0d: got %h want %h", i, lights, exp_v);
      end
      $display("[%0t] l2r step %0d lights=%h", $time, i, lights);
    end
  endtask

  task automatic test_sweep_r2l();
    logic [7:0] exp_v;
    mode = 2'b01;
    // 01,02,...,80,01,02,04,08
    for (int i = 0; i < 12; i++) begin
      wait_tick("r2l");
      exp_v = 8'h01 << (i % 8);
      checks++;
      if (lights !== exp_v) begin
        errors++;
        $display("FAIL r2l_step%0d: got %h want %h", i, lights, exp_v);
      end
      $display("[%0t] r2l step %0d lights=%h", $time, i, lights);
    end
    mode = 2'b10;
    wait_tick("r2l_switch");
    checks++;
    if (lights !== 8'h80) begin
      errors++;
      $display("FAIL r2l_to_l2r_seed: got %h want 80", lights);
    end
    $display("[%0t] switch to l2r lights=%h", $time, lights);
  endtask

  task automatic test_mode_glitch();
    // Glitch on mode between ticks must not be seen (still sweeping L->R from 80).
    step();
    mode = 2'b00;
    step();
    mode = 2'b10;
    wait_tick("glitch");
    checks++;
    if (lights !== 8'h40) begin
      errors++;
      $display("FAIL glitch_ignored: got %h want 40", lights);
    end
    $display("[%0t] glitch lights=%h", $time, lights);
    // Change held across a tick applies exactly at that tick.
    mode = 2'b01;
    step();
    step();
    step();
    checks++;
    if (tick !== 1'b1 || lights !== 8'h40) begin
      errors++;
      $display("FAIL held_pre_tick: got tick=%b lights=%h want tick=1 lights=40", tick, lights);
    end
    step();
    checks++;
    if (lights !== 8'h01) begin
      errors++;
      $display("FAIL held_apply: got %h want 01", lights);
    end
    $display("[%0t] held change lights=%h", $time, lights);
  endtask

  task automatic test_aux();
    logic [7:0] exp_v;
    // From 01 sweep R->L to 20: 02,04,08,10,20.
    for (int i = 0; i < 5; i++) wait_tick("aux_prep");
    checks++;
    if (lights !== 8'h20) begin
      errors++;
      $display("FAIL aux_prep: got %h want 20", lights);
    end
    mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      wait_tick("aux");
`ifdef RUNWAY_FLASH_EN
      exp_v = (i % 2 == 0) ? 8'hFF : 8'h00;
`else
      exp_v = 8'h20;
`endif
      checks++;
      if (lights !== exp_v) begin
        errors++;
        $display("FAIL aux_step%0d: got %h want %h", i, lights, exp_v);
      end
      $display("[%0t] aux step %0d lights=%h", $time, i, lights);
    end
    mode = 2'b00;
    wait_tick("aux_exit");
    checks++;
    if (lights !== 8'h81) begin
      errors++;
      $display("FAIL aux_exit_calm: got %h want 81", lights);
    end
    wait_tick("aux_exit2");
    checks++;
    if (lights !== 8'h7E) begin
      errors++;
      $display("FAIL aux_exit_calm2: got %h want 7E", lights);
    end
    $display("[%0t] aux exit lights=%h", $time, lights);
  endtask

  task automatic test_reset_on_tick();
    mode = 2'b01;
    wait_tick("rst_prep");   // seed 01
    wait_tick("rst_prep2");  // 02
    checks++;
    if (lights !== 8'h02) begin
      errors++;
      $display("FAIL rst_prep: got %h want 02", lights);
    end
    step();
    step();
    step();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL rst_tick_cycle: got %b want 1", tick);
    end
    Reset = 1'b1;
    step();
    checks++;
    if (lights !== 8'h81 || tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_on_tick: got lights=%h tick=%b want lights=81 tick=0", lights, tick);
    end
    $display("[%0t] reset on tick lights=%h tick=%b", $time, lights, tick);
    Reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (tick !== (c == 3) || lights !== 8'h81) begin
        errors++;
        $display("FAIL rst_release c%0d: got tick=%b lights=%h want tick=%b lights=81",
                 c, tick, lights, (c == 3));
      end
    end
    step();
    checks++;
    if (lights !== 8'h01) begin
      errors++;
      $display("FAIL rst_first_tick: got %h want 01", lights);
    end
    $display("[%0t] after reset first tick lights=%h", $time, lights);
  endtask

  initial begin
    Reset = 1'b1;
    mode  = 2'b00;
    test_reset();
    test_calm();
    test_sweep_l2r();
    test_sweep_r2l();
    test_mode_glitch();
    test_aux();
    test_reset_on_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
